// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, NOP opcode and access FSM state type for the MEM stage
package mem_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_NOP = '0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - ready-handshaked data-memory port between the MEM stage and data memory
interface mem_stage_if #(
    parameter int DATA_W = 16
) ();

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );

endinterface

// File: rtl/mem_access_fsm.sv
// rtl/mem_access_fsm.sv - IDLE/WAIT access tracker with timeout abort, stall generation and sticky error
module mem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_op,
    input  logic dmem_ready,
    output logic timeout_hit,
    output logic stall,
    output logic mem_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    mem_state_e state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;

    // A ready arriving in the abort cycle wins: the access completes normally.
    assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q == TIMEOUT_CNT) && !dmem_ready;
    assign stall       = mem_op && !dmem_ready && !timeout_hit;
    assign mem_err     = mem_err_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_op && !dmem_ready) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            ST_WAIT: begin
                if (dmem_ready) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = 8'd0;
                    mem_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory access, EX stall, MEM/WB register and stall counter
module mem_stage #(
    parameter int DATA_W  = mem_stage_pkg::DATA_W,
    parameter int REG_W   = mem_stage_pkg::REG_W,
    parameter int OP_W    = mem_stage_pkg::OP_W,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ex_alu_res,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_op_dest,
    input  logic              ex_mem_write_en,
    input  logic              ex_wb_mux,
    input  logic              ex_wb_en,
    input  logic [OP_W-1:0]   ex_opcode,
    mem_stage_if.master       dmem,
    output logic              stall_mem_ready,
    output logic [DATA_W-1:0] mem_res,
    output logic [REG_W-1:0]  mem_op_dest,
    output logic              mem_wb_en,
    output logic [OP_W-1:0]   mem_opcode,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cycles
);

    import mem_stage_pkg::OP_NOP;

    logic mem_op;
    logic stall;
    logic timeout_hit;

    logic [DATA_W-1:0] mem_res_q, mem_res_d;
    logic [REG_W-1:0]  mem_op_dest_q, mem_op_dest_d;
    logic              mem_wb_en_q, mem_wb_en_d;
    logic [OP_W-1:0]   mem_opcode_q, mem_opcode_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

    assign mem_op = ex_mem_write_en | (ex_wb_mux & ex_wb_en);

    assign dmem.dmem_req   = mem_op;
    assign dmem.dmem_we    = ex_mem_write_en;
    assign dmem.dmem_addr  = ex_alu_res;
    assign dmem.dmem_wdata = ex_store_data;

    mem_access_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_op     (mem_op),
        .dmem_ready (dmem.dmem_ready),
        .timeout_hit(timeout_hit),
        .stall      (stall),
        .mem_err    (mem_err)
    );

    assign stall_mem_ready = stall;

    always_comb begin
        mem_res_d      = mem_res_q;
        mem_op_dest_d  = mem_op_dest_q;
        mem_wb_en_d    = mem_wb_en_q;
        mem_opcode_d   = mem_opcode_q;
        stall_cycles_d = stall_cycles_q;

        if (stall) begin
            // Bubble into WB; mem_res keeps the last value for forwarding.
            mem_wb_en_d   = 1'b0;
            mem_op_dest_d = '0;
            mem_opcode_d  = OP_W'(OP_NOP);
        end else begin
            mem_wb_en_d   = ex_wb_en;
            mem_op_dest_d = ex_op_dest;
            mem_opcode_d  = ex_opcode;
            if (!ex_wb_mux) begin
                mem_res_d = ex_alu_res;
            end else if (timeout_hit) begin
                mem_res_d = '0;
            end else begin
                mem_res_d = dmem.dmem_rdata;
            end
        end

        if (stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_res_q      <= '0;
            mem_op_dest_q  <= '0;
            mem_wb_en_q    <= 1'b0;
            mem_opcode_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            mem_res_q      <= mem_res_d;
            mem_op_dest_q  <= mem_op_dest_d;
            mem_wb_en_q    <= mem_wb_en_d;
            mem_opcode_q   <= mem_opcode_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem_res      = mem_res_q;
    assign mem_op_dest  = mem_op_dest_q;
    assign mem_wb_en    = mem_wb_en_q;
    assign mem_opcode   = mem_opcode_q;
    assign stall_cycles = stall_cycles_q;

endmodule
